// File: rtl/vga_sync_generator.sv
// Vertical line counter and registered 640x480@60 Hz sync/blanking/coordinate decode,
// driven by an external horizontal counter. Malformed horizontal timing raises a sticky error.
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        enable_v_counter,
  input  logic [15:0] h_count_value,
  output logic [15:0] v_count_value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic        timing_error
);

  localparam logic [15:0] H_TOTAL  = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] V_TOTAL  = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [15:0] v_count_q, v_count_d, v_next, v_line;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_q, video_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic        frame_q, frame_d;
  logic        error_q, error_d;
  logic        h_valid;

  always_comb begin
    v_next    = (v_count_q == V_TOTAL - 16'd1) ? 16'd0 : v_count_q + 16'd1;
    v_count_d = enable_v_counter ? v_next : v_count_q;
    // Decode against the line being entered so h=0 already sees the new line.
    v_line    = v_count_d;
    h_valid   = h_count_value < H_TOTAL;

    hsync_d   = !(h_valid && (h_count_value >= HS_START) && (h_count_value < HS_END));
    vsync_d   = !((v_line >= VS_START) && (v_line < VS_END));
    video_d   = h_valid && (h_count_value < H_VIS) && (v_line < V_VIS);
    pixel_x_d = video_d ? h_count_value[9:0] : 10'd0;
    pixel_y_d = video_d ? v_line[9:0] : 10'd0;
    frame_d   = (h_count_value == 16'd0) && (v_line == 16'd0);
    error_d   = error_q || !h_valid || (enable_v_counter && (h_count_value != 16'd0));
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      v_count_q <= 16'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      video_q   <= 1'b0;
      pixel_x_q <= 10'd0;
      pixel_y_q <= 10'd0;
      frame_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      video_q   <= video_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      frame_q   <= frame_d;
      error_q   <= error_d;
    end
  end

  assign v_count_value = v_count_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign video_on      = video_q;
  assign pixel_x       = pixel_x_q;
  assign pixel_y       = pixel_y_q;
  assign frame_start   = frame_q;
  assign timing_error  = error_q;

endmodule
